dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the core's dmem request/response interface.

---
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: samples byte-masked read/write requests, waits, accesses a word array,
// pulses dmem_resp. Latency: sample cycle N -> resp at N+2+WAIT_CYCLES (up to +3 more with DMEM_RAND_WAIT_EN).
// Backpressure: none; the initiator holds its request until resp, and inputs are ignored outside IDLE.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wmask;
    logic [4:0]  r_cnt;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_req, w_in_range;
    logic [4:0]  w_load_cnt;
    logic [31:0] w_off, w_idx;

    assign w_req      = (|dmem_rmask) | (|dmem_wmask);
    assign w_off      = r_addr - BASE_ADDR;
    assign w_idx      = w_off >> 2;
    assign w_in_range = (w_idx < 32'(DEPTH_WORDS));

`ifdef DMEM_RAND_WAIT_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running so the extra wait depends on request timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_load_cnt = 5'(WAIT_CYCLES) + {3'b000, r_lfsr[1:0]};
`else
    assign w_load_cnt = 5'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_next = (w_load_cnt == 5'd0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (r_cnt <= 5'd1) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // rmask only qualifies the request: the full word is always returned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_addr  <= dmem_addr;
                    r_wdata <= dmem_wdata;
                    r_wmask <= dmem_wmask;
                    r_cnt   <= w_load_cnt;
                end
                S_WAIT: r_cnt <= r_cnt - 5'd1;
                S_ACCESS: begin
                    r_rdata <= w_in_range ? r_mem[w_idx[AW-1:0]] : 32'hDEAD_BEEF;
                    r_err   <= ~w_in_range;
                end
                default: ;
            endcase
        end
    end

    // Array is not reset; the read above sees the pre-write word
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wmask[i]) r_mem[w_idx[AW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign dmem_rdata = r_rdata;
    assign dmem_resp  = (r_state == S_RESP);
    assign dmem_err   = (r_state == S_RESP) & r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-level memory model with latency checks.
module tb_dmem_responder;
    localparam int          DEPTH = 1024;
    localparam int          WC    = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_RAND_WAIT_EN
    localparam int XW = 3;
`else
    localparam int XW = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp, dmem_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dmem_err(dmem_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mdl [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        @(negedge clk);
    endtask

    // Word-level model: returns the pre-access word, then applies the byte writes
    task automatic mdl_access(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd,
                              output logic [31:0] erd, output logic eer, output bit known);
        logic [31:0] ix;
        logic [31:0] w;
        ix = (a - BASE) >> 2;
        known = 1'b1;
        if (ix >= DEPTH) begin
            erd = 32'hDEAD_BEEF;
            eer = 1'b1;
        end else begin
            eer   = 1'b0;
            known = mdl.exists(ix);
            erd   = known ? mdl[ix] : 32'h0;
            w     = erd;
            for (int i = 0; i < 4; i++) if (wm[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (wm != 4'h0) begin
                mdl[ix] = known ? w : (wm == 4'hF ? wd : 32'h0);
                if (!known && wm != 4'hF) mdl.delete(ix);
            end
        end
    endtask

    // Drives a request at a negedge and waits for its response; lat counts cycles to the resp
    task automatic do_req(input string tag, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd, input int lo, input int hi,
                          output logic [31:0] rd, output int lat);
        logic [31:0] erd;
        logic        eer;
        bit          known;
        bit          got;
        dmem_addr  = a;
        dmem_rmask = rm;
        dmem_wmask = wm;
        dmem_wdata = wd;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            lat++;
            got = dmem_resp;
        end
        rd = dmem_rdata;
        mdl_access(a, wm, wd, erd, eer, known);
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_lat"}, 32'((lat >= lo) && (lat <= hi)), 32'd1);
            chk({tag, "_err"}, 32'(dmem_err), 32'(eer));
            if (known) chk({tag, "_rdata"}, dmem_rdata, erd);
        end
    endtask

    logic [31:0] rd;
    int          lat, resp_cnt, n_lat;
    bit [15:0]   lat_seen;

    initial begin
        rst = 1'b1;
        dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_resp", 32'(dmem_resp), 32'd0);
        chk("rst_err", 32'(dmem_err), 32'd0);
        chk("rst_rdata", dmem_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full write then read, partial lane write then read
        do_req("t1_wr", 32'h10, 4'h0, 4'hF, 32'hA5A5_1234, 2+WC, 2+WC+XW, rd, lat);
        idle();
        do_req("t1_rd", 32'h10, 4'hF, 4'h0, 32'h0, 2+WC, 2+WC+XW, rd, lat);
        chk("t1_const", rd, 32'hA5A5_1234);
        idle();
        do_req("t2_wr", 32'h10, 4'h0, 4'b0100, 32'h00CC_0000, 2+WC, 2+WC+XW, rd, lat);
        idle();
        do_req("t2_rd", 32'h10, 4'h1, 4'h0, 32'h0, 2+WC, 2+WC+XW, rd, lat);
        chk("t2_const", rd, 32'hA5CC_1234);
        idle();

        // Out-of-range reads/writes, including the wrapped top of the address space
        do_req("t3_oor", DEPTH*4, 4'hF, 4'h0, 32'h0, 2+WC, 2+WC+XW, rd, lat);
        chk("t3_const", rd, 32'hDEAD_BEEF);
        idle();
        do_req("t3_oorw", 32'hFFFF_FFFC, 4'hF, 4'hF, 32'h5555_AAAA, 2+WC, 2+WC+XW, rd, lat);
        idle();
        do_req("t3_rd", 32'h10, 4'hF, 4'h0, 32'h0, 2+WC, 2+WC+XW, rd, lat);
        idle();
        do_req("t3_rmw", 32'h10, 4'hF, 4'b0011, 32'hFFFF_0077, 2+WC, 2+WC+XW, rd, lat);
        chk("t3_rmw_old", rd, 32'hA5CC_1234);
        idle();

        // Reset while in WAIT aborts the write and issues no response
        do_req("t4_init", 32'h20, 4'h0, 4'hF, 32'h2222_3333, 2+WC, 2+WC+XW, rd, lat);
        idle();
        dmem_addr = 32'h20; dmem_wmask = 4'hF; dmem_wdata = 32'h1111_1111;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t4_rst_resp", 32'(dmem_resp), 32'd0);
        chk("t4_rst_rdata", dmem_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_wmask = 4'h0;
        resp_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (dmem_resp) resp_cnt++;
        end
        chk("t4_no_resp", 32'(resp_cnt), 32'd0);
        do_req("t4_rd", 32'h20, 4'hF, 4'h0, 32'h0, 2+WC, 2+WC+XW, rd, lat);
        chk("t4_const", rd, 32'h2222_3333);
        idle();

        // Back-to-back: each request driven in the resp cycle of the previous one
        for (int i = 0; i < 8; i++) begin
            do_req("t5_init", 32'h40 + 4*i, 4'h0, 4'hF, $urandom, 2+WC, 3+WC+XW, rd, lat);
        end
        idle();
        do_req("t5_rd0", 32'h40, 4'hF, 4'h0, 32'h0, 2+WC, 2+WC+XW, rd, lat);
        for (int i = 1; i < 8; i++) begin
            do_req("t5_b2b", 32'h40 + 4*i, 4'hF, 4'h0, 32'h0, 3+WC, 3+WC+XW, rd, lat);
        end
        idle();

        // Random traffic over a small initialized pool plus occasional out-of-range hits
        for (int i = 0; i < 16; i++) begin
            do_req("t6_init", 32'h100 + 4*i, 4'h0, 4'hF, $urandom, 2+WC, 3+WC+XW, rd, lat);
        end
        idle();
        lat_seen = '0;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [3:0]  rm, wm;
            a  = ($urandom_range(0, 7) == 0) ? (DEPTH*4 + 4*$urandom_range(0, 15))
                                             : (32'h100 + 4*$urandom_range(0, 15));
            rm = 4'($urandom);
            wm = 4'($urandom);
            if (rm == 4'h0 && wm == 4'h0) rm = 4'hF;
            do_req("t6_rnd", a, rm, wm, $urandom, 2+WC, 2+WC+XW, rd, lat);
            if (lat < 16) lat_seen[lat] = 1'b1;
            dmem_rmask = 4'h0;
            dmem_wmask = 4'h0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        n_lat = $countones(lat_seen);
`ifdef DMEM_RAND_WAIT_EN
        chk("t6_distinct_lat", 32'(n_lat >= 3), 32'd1);
`else
        chk("t6_single_lat", 32'(n_lat), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
